// File: rtl/uart_rx_framer.sv
// UART receive framer: oversampled start/data/stop framing with a
// single-entry valid/ready output holding register.
module uart_rx_framer #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  in,
  input  logic                  fall,
  input  logic                  ready,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  output logic                  frameErr,
  output logic                  overrun,
  output logic                  busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t                r_state, w_state_nx;
  logic [CW-1:0]         r_cnt, w_cnt_nx;
  logic [BW-1:0]         r_idx, w_idx_nx;
  logic [DATA_WIDTH-1:0] r_shift, w_shift_nx;
  logic [DATA_WIDTH-1:0] r_data, w_data_nx;
  logic                  r_valid, w_valid_nx;
  logic                  r_ferr, w_ferr_nx;
  logic                  r_ovr, w_ovr_nx;
  logic                  w_stop_ok;
  logic                  w_cnt_last;
  logic                  w_cnt_mid;
  logic                  w_idx_last;

  assign w_cnt_last = (r_cnt == CW'(OVERSAMPLE - 1));
  assign w_cnt_mid  = (r_cnt == CW'(OVERSAMPLE / 2 - 1));
  assign w_idx_last = (r_idx == BW'(DATA_WIDTH - 1));

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_idx_nx   = r_idx;
    w_shift_nx = r_shift;
    w_data_nx  = r_data;
    w_valid_nx = r_valid;
    w_ferr_nx  = 1'b0;
    w_ovr_nx   = 1'b0;
    w_stop_ok  = 1'b0;
    if (en) begin
      unique case (r_state)
        S_IDLE: begin
          if (fall) begin
            w_state_nx = S_START;
            w_cnt_nx   = '0;
          end
        end
        S_START: begin
          if (w_cnt_mid) begin
            w_cnt_nx = '0;
            w_idx_nx = '0;
            // A line that is high again mid start bit was only a glitch
            w_state_nx = in ? S_IDLE : S_DATA;
          end else begin
            w_cnt_nx = r_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (w_cnt_last) begin
            w_shift_nx = r_shift >> 1;
            w_shift_nx[DATA_WIDTH-1] = in;
            w_cnt_nx = '0;
            w_idx_nx = r_idx + BW'(1);
            if (w_idx_last) w_state_nx = S_STOP;
          end else begin
            w_cnt_nx = r_cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (w_cnt_last) begin
            w_cnt_nx   = '0;
            w_state_nx = S_IDLE;
            w_ferr_nx  = ~in;
            w_stop_ok  = in;
          end else begin
            w_cnt_nx = r_cnt + CW'(1);
          end
        end
        default: w_state_nx = S_IDLE;
      endcase
    end
    // Handshake runs every cycle; a full holder with no taker drops the frame
    if (w_stop_ok) begin
      if (!r_valid || ready) begin
        w_data_nx  = r_shift;
        w_valid_nx = 1'b1;
      end else begin
        w_ovr_nx = 1'b1;
      end
    end else if (r_valid && ready) begin
      w_valid_nx = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_idx   <= w_idx_nx;
      r_shift <= w_shift_nx;
      r_data  <= w_data_nx;
      r_valid <= w_valid_nx;
      r_ferr  <= w_ferr_nx;
      r_ovr   <= w_ovr_nx;
    end
  end

  assign data     = r_data;
  assign valid    = r_valid;
  assign frameErr = r_ferr;
  assign overrun  = r_ovr;
  assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_framer.sv
// Bench for uart_rx_framer: directed frame table, corner sequences and
// random frames against a tick-arithmetic reference model.
module tb_uart_rx_framer;

  localparam int OS = 16;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          en = 1'b0;
  logic          in_l = 1'b1;
  logic          fall = 1'b0;
  logic          ready = 1'b0;
  logic [DW-1:0] data;
  logic          valid;
  logic          frameErr;
  logic          overrun;
  logic          busy;

  uart_rx_framer #(.OVERSAMPLE(OS), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .en(en), .in(in_l), .fall(fall),
    .data(data), .valid(valid), .ready(ready),
    .frameErr(frameErr), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  bit          prev_line = 1'b1;
  bit          rnd_ready = 1'b0;
  int          fe_cnt = 0;
  int          ov_cnt = 0;
  logic [7:0]  got_q[$];

  // reference model: ticks counted since the start edge
  bit          m_act;
  int          m_rel;
  logic [DW-1:0] m_bits, m_data;
  bit          m_valid, m_fe, m_ov;

  typedef struct {
    bit         rst;
    logic [7:0] d;
    bit         stopb;
    logic [7:0] exp_data;
    bit         exp_valid;
    int         exp_fe;
    int         exp_ov;
  } row_t;

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic model_step();
    bit good;
    int k;
    good = 1'b0;
    if (reset) begin
      m_act = 0; m_rel = 0; m_bits = '0; m_data = '0;
      m_valid = 0; m_fe = 0; m_ov = 0;
      return;
    end
    m_fe = 0;
    m_ov = 0;
    if (en) begin
      if (!m_act) begin
        if (fall) begin
          m_act = 1;
          m_rel = 0;
        end
      end else begin
        m_rel++;
        if (m_rel == OS / 2) begin
          if (in_l) m_act = 0;
        end else if (m_rel > OS / 2 && (m_rel - OS / 2) % OS == 0) begin
          k = (m_rel - OS / 2) / OS;
          if (k <= DW) m_bits[k-1] = in_l;
          else begin
            m_act = 0;
            if (!in_l) m_fe = 1;
            else good = 1;
          end
        end
      end
    end
    if (good) begin
      if (!m_valid || ready) begin
        m_data = m_bits;
        m_valid = 1;
      end else m_ov = 1;
    end else if (m_valid && ready) m_valid = 0;
  endtask

  task automatic cyc(bit e, bit f, bit r, bit rs);
    en = e;
    fall = f;
    reset = rs;
    ready = rnd_ready ? 1'($urandom_range(0, 1)) : r;
    if (valid && ready && !reset) got_q.push_back(data);
    @(posedge clk);
    model_step();
    #1;
    chk("cycle", {busy, overrun, frameErr, valid, data},
        {m_act, m_ov, m_fe, m_valid, m_data});
    fe_cnt += int'(frameErr);
    ov_cnt += int'(overrun);
    @(negedge clk);
  endtask

  task automatic tick(bit line, bit re, bit rr);
    bit f;
    f = prev_line & ~line;
    prev_line = line;
    in_l = line;
    cyc(1'b1, f, re, 1'b0);
    repeat (3) cyc(1'b0, 1'b0, rr, 1'b0);
  endtask

  task automatic idle(int n, bit r);
    repeat (n) tick(1'b1, r, r);
  endtask

  task automatic send_frame(logic [7:0] d, bit sb, int st, bit r, bit r_at);
    repeat (OS) tick(1'b0, r, r);
    for (int i = 0; i < DW; i++) repeat (OS) tick(d[i], r, r);
    for (int j = 0; j < st; j++) tick(sb, r | (r_at && j == OS / 2), r);
  endtask

  task automatic do_reset();
    in_l = 1'b1;
    prev_line = 1'b1;
    rnd_ready = 1'b0;
    repeat (3) cyc(1'b0, 1'b0, 1'b1, 1'b1);
    chk("reset_state", {busy, overrun, frameErr, valid, data}, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    fe_cnt = 0;
    ov_cnt = 0;
    got_q.delete();
  endtask

  initial begin
    row_t rows[5];
    logic [7:0] pb;
    int r;
    rows[0] = '{1'b1, 8'hA5, 1'b1, 8'hA5, 1'b1, 0, 0};
    rows[1] = '{1'b1, 8'h3C, 1'b0, 8'h00, 1'b0, 1, 0};
    rows[2] = '{1'b1, 8'h11, 1'b1, 8'h11, 1'b1, 0, 0};
    rows[3] = '{1'b0, 8'h22, 1'b1, 8'h11, 1'b1, 0, 1};
    rows[4] = '{1'b1, 8'h80, 1'b1, 8'h80, 1'b1, 0, 0};

    for (int i = 0; i < 5; i++) begin
      if (rows[i].rst) do_reset();
      send_frame(rows[i].d, rows[i].stopb, OS, 1'b0, 1'b0);
      idle(4, 1'b0);
      chk("row_data", data, rows[i].exp_data);
      chk("row_valid", valid, rows[i].exp_valid);
      chk("row_ferr", fe_cnt, rows[i].exp_fe);
      chk("row_ovr", ov_cnt, rows[i].exp_ov);
      chk("row_busy", busy, 0);
    end

    // one-cycle ready consumes the held frame
    do_reset();
    send_frame(8'hA5, 1'b1, OS, 1'b0, 1'b0);
    idle(2, 1'b0);
    chk("hs_valid_before", valid, 1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("hs_valid_after", valid, 0);

    // short low glitch is rejected at the start sample
    do_reset();
    repeat (3) tick(1'b0, 1'b0, 1'b0);
    chk("glitch_busy", busy, 1);
    repeat (3) tick(1'b0, 1'b0, 1'b0);
    idle(12, 1'b0);
    chk("glitch_idle", {busy, valid, frameErr}, 0);
    chk("glitch_ferr", fe_cnt, 0);

    // ready at the stop sample makes room for the second frame
    do_reset();
    send_frame(8'h11, 1'b1, OS, 1'b0, 1'b0);
    idle(2, 1'b0);
    send_frame(8'h22, 1'b1, OS, 1'b0, 1'b1);
    idle(2, 1'b0);
    chk("ovr2_data", data, 8'h22);
    chk("ovr2_valid", valid, 1);
    chk("ovr2_ovr", ov_cnt, 0);

    // reset during the fourth data bit abandons the frame
    do_reset();
    pb = 8'h5A;
    repeat (OS) tick(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) repeat (OS) tick(pb[i], 1'b0, 1'b0);
    repeat (OS / 2) tick(pb[3], 1'b0, 1'b0);
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    idle(4, 1'b0);
    chk("abort_out", {busy, valid, data}, 0);
    send_frame(8'h80, 1'b1, OS, 1'b0, 1'b0);
    idle(2, 1'b0);
    chk("abort_next_data", data, 8'h80);
    chk("abort_next_valid", valid, 1);
    chk("abort_next_err", fe_cnt + ov_cnt, 0);

    // back-to-back frames, second edge one tick after the stop sample
    do_reset();
    send_frame(8'h00, 1'b1, OS / 2 + 1, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, OS, 1'b1, 1'b0);
    idle(4, 1'b1);
    chk("b2b_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("b2b_first", got_q[0], 8'h00);
      chk("b2b_second", got_q[1], 8'hFF);
    end
    chk("b2b_err", fe_cnt + ov_cnt, 0);

    // random frames, glitches and ready
    do_reset();
    rnd_ready = 1'b1;
    repeat (30) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        repeat ($urandom_range(1, 7)) tick(1'b0, 1'b0, 1'b0);
        idle(10, 1'b0);
      end else begin
        send_frame(8'($urandom), r != 1, $urandom_range(OS / 2 + 1, 20),
                   1'b0, 1'b0);
        idle($urandom_range(1, 4), 1'b0);
      end
    end
    rnd_ready = 1'b0;
    idle(4, 1'b0);
    chk("rand_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
